// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: an instruction-fetch port and a
// data-stage port share one single-outstanding memory interface. The data
// side normally wins, but a waiting fetch is forced through after DS_BURST
// back-to-back data grants so it cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_L   = 32,
  parameter int DATA_L   = 32,
  parameter int DS_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester
  input  logic              if_re,
  input  logic [ADDR_L-1:0] if_addr,
  input  logic [1:0]        if_len,
  input  logic              if_abort,
  output logic              if_rack,
  output logic [DATA_L-1:0] if_rdata,
  // data-stage requester
  input  logic              ds_re,
  input  logic              ds_we,
  input  logic [ADDR_L-1:0] ds_addr,
  input  logic [DATA_L-1:0] ds_wdata,
  input  logic [1:0]        ds_len,
  output logic              ds_ack,
  output logic [DATA_L-1:0] ds_rdata,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_L-1:0] mem_addr,
  output logic [DATA_L-1:0] mem_wdata,
  output logic [1:0]        mem_len,
  input  logic              mem_ack,
  input  logic [DATA_L-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DS, DONE} state_t;

  localparam logic [3:0] BURST_MAX = 4'(DS_BURST);

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_L-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_L-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_len_q, mem_len_d;
  logic                if_rack_q, if_rack_d;
  logic                ds_ack_q, ds_ack_d;
  logic [DATA_L-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_L-1:0]   ds_rdata_q, ds_rdata_d;
  logic [3:0]          ds_cnt_q, ds_cnt_d;
  logic                abort_q, abort_d;

  logic ds_req;
  logic fetch_starved;

  assign ds_req        = ds_re | ds_we;
  assign fetch_starved = (ds_cnt_q == BURST_MAX) && if_re;

  // Next-state, grant latching and completion handling.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_len_d   = mem_len_q;
    if_rack_d   = 1'b0;
    ds_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ds_rdata_d  = ds_rdata_q;
    ds_cnt_d    = ds_cnt_q;
    abort_d     = abort_q;

    case (state_q)
      IDLE: begin
        if (!if_re) begin
          ds_cnt_d = 4'd0;
        end
        if (ds_req && !fetch_starved) begin
          state_d     = GNT_DS;
          mem_req_d   = 1'b1;
          mem_we_d    = ds_we;  // read+write together is a write
          mem_addr_d  = ds_addr;
          mem_wdata_d = ds_wdata;
          mem_len_d   = ds_len;
          if (if_re && (ds_cnt_q != BURST_MAX)) begin
            ds_cnt_d = ds_cnt_q + 4'd1;
          end
        end else if (if_re) begin
          state_d     = GNT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_len_d   = if_len;
          ds_cnt_d    = 4'd0;
        end
      end
      GNT_IF: begin
        if (if_abort) begin
          abort_d = 1'b1;
        end
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          abort_d   = 1'b0;
          // an abort seen in the ack cycle itself also suppresses delivery
          if (!(abort_q || if_abort)) begin
            if_rack_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      GNT_DS: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ds_ack_d  = 1'b1;
          if (!mem_we_q) begin
            ds_rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        // one dead cycle so a request still held after its ack is not re-issued
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_len_q   <= 2'd0;
      if_rack_q   <= 1'b0;
      ds_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ds_rdata_q  <= '0;
      ds_cnt_q    <= 4'd0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_len_q   <= mem_len_d;
      if_rack_q   <= if_rack_d;
      ds_ack_q    <= ds_ack_d;
      if_rdata_q  <= if_rdata_d;
      ds_rdata_q  <= ds_rdata_d;
      ds_cnt_q    <= ds_cnt_d;
      abort_q     <= abort_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_len   = mem_len_q;
  assign if_rack   = if_rack_q;
  assign ds_ack    = ds_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ds_rdata  = ds_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus a hand-written
// sequence for the fetch anti-starvation burst limit.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_re, if_abort, if_rack;
  logic [31:0] if_addr, if_rdata;
  logic [1:0]  if_len;
  logic        ds_re, ds_we, ds_ack;
  logic [31:0] ds_addr, ds_wdata, ds_rdata;
  logic [1:0]  ds_len;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_len;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_L(32), .DATA_L(32), .DS_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .if_re(if_re), .if_addr(if_addr), .if_len(if_len), .if_abort(if_abort),
    .if_rack(if_rack), .if_rdata(if_rdata),
    .ds_re(ds_re), .ds_we(ds_we), .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_len(ds_len), .ds_ack(ds_ack), .ds_rdata(ds_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic        rst, if_re, if_abort, ds_re, ds_we, mem_ack;
    logic [31:0] if_addr, ds_addr, ds_wdata, mem_rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_rack, e_dsack, e_busy;
    logic [31:0] e_ifr, e_dsr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, ir, ab, dr, dw, ma,
    input logic [31:0] ia, da, dwd, mrd,
    input logic ereq, ewe,
    input logic [31:0] eaddr, ewd,
    input logic erack, edsack, ebusy,
    input logic [31:0] eifr, edsr);
    vec_t v;
    v.rst = r; v.if_re = ir; v.if_abort = ab; v.ds_re = dr; v.ds_we = dw;
    v.mem_ack = ma; v.if_addr = ia; v.ds_addr = da; v.ds_wdata = dwd;
    v.mem_rdata = mrd; v.e_req = ereq; v.e_we = ewe; v.e_addr = eaddr;
    v.e_wdata = ewd; v.e_rack = erack; v.e_dsack = edsack; v.e_busy = ebusy;
    v.e_ifr = eifr; v.e_dsr = edsr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; if_re = v.if_re; if_abort = v.if_abort; ds_re = v.ds_re;
    ds_we = v.ds_we; mem_ack = v.mem_ack; if_addr = v.if_addr;
    ds_addr = v.ds_addr; ds_wdata = v.ds_wdata; mem_rdata = v.mem_rdata;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk("mem_req",   i, {31'd0, mem_req}, {31'd0, v.e_req});
    chk("mem_we",    i, {31'd0, mem_we},  {31'd0, v.e_we});
    chk("mem_addr",  i, mem_addr,  v.e_addr);
    chk("mem_wdata", i, mem_wdata, v.e_wdata);
    chk("if_rack",   i, {31'd0, if_rack}, {31'd0, v.e_rack});
    chk("ds_ack",    i, {31'd0, ds_ack},  {31'd0, v.e_dsack});
    chk("busy",      i, {31'd0, busy},    {31'd0, v.e_busy});
    chk("if_rdata",  i, if_rdata, v.e_ifr);
    chk("ds_rdata",  i, ds_rdata, v.e_dsr);
    $display("step %0d: req=%0b we=%0b addr=%08h rack=%0b dsack=%0b busy=%0b ifr=%08h dsr=%08h",
             i, mem_req, mem_we, mem_addr, if_rack, ds_ack, busy, if_rdata, ds_rdata);
  endtask

  initial begin
    // rst ir ab dr dw ma | if_addr ds_addr ds_wdata mem_rdata | req we addr wdata rack dsack busy ifr dsr
    // reset
    tbl.push_back(mk(1,0,0,0,0,0, 32'h0,32'h0,32'h0,32'h0,              0,0,32'h0,32'h0,0,0,0,32'h0,32'h0));
    // simple fetch, request held into DONE, dropped in IDLE
    tbl.push_back(mk(0,1,0,0,0,0, 32'h1000,0,0,0,                       1,0,32'h1000,32'h0,0,0,1,32'h0,32'h0));
    tbl.push_back(mk(0,1,0,0,0,1, 32'h1000,0,0,32'h13,                  0,0,32'h1000,32'h0,1,0,1,32'h13,32'h0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h1000,0,0,0,                       0,0,32'h1000,32'h0,0,0,0,32'h13,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0, 32'h1000,0,0,0,                       0,0,32'h1000,32'h0,0,0,0,32'h13,32'h0));
    // simultaneous fetch + write: write first, fetch after DONE
    tbl.push_back(mk(0,1,0,0,1,0, 32'h1004,32'h2000,32'hDEADBEEF,0,     1,1,32'h2000,32'hDEADBEEF,0,0,1,32'h13,32'h0));
    tbl.push_back(mk(0,1,0,0,0,1, 32'h1004,32'h9999,32'h0,32'h55,       0,0,32'h2000,32'hDEADBEEF,0,1,1,32'h13,32'h0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h1004,0,0,0,                       0,0,32'h2000,32'hDEADBEEF,0,0,0,32'h13,32'h0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h1004,0,0,0,                       1,0,32'h1004,32'h0,0,0,1,32'h13,32'h0));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h1004,0,0,0,                       1,0,32'h1004,32'h0,0,0,1,32'h13,32'h0));
    tbl.push_back(mk(0,0,0,0,0,1, 32'h0,0,0,32'h77,                     0,0,32'h1004,32'h0,1,0,1,32'h77,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,                              0,0,32'h1004,32'h0,0,0,0,32'h77,32'h0));
    // data read, request held past ack, then re-issued from IDLE
    tbl.push_back(mk(0,0,0,1,0,0, 0,32'h3000,32'h11111111,0,            1,0,32'h3000,32'h11111111,0,0,1,32'h77,32'h0));
    tbl.push_back(mk(0,0,0,1,0,1, 0,32'h3000,32'h11111111,32'hCAFE0001, 0,0,32'h3000,32'h11111111,0,1,1,32'h77,32'hCAFE0001));
    tbl.push_back(mk(0,0,0,1,0,0, 0,32'h3000,32'h11111111,0,            0,0,32'h3000,32'h11111111,0,0,0,32'h77,32'hCAFE0001));
    tbl.push_back(mk(0,0,0,1,0,0, 0,32'h3000,32'h11111111,0,            1,0,32'h3000,32'h11111111,0,0,1,32'h77,32'hCAFE0001));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,32'hCAFE0002,                   0,0,32'h3000,32'h11111111,0,1,1,32'h77,32'hCAFE0002));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,                              0,0,32'h3000,32'h11111111,0,0,0,32'h77,32'hCAFE0002));
    // aborted fetch: completes on memory, no rack, rdata kept
    tbl.push_back(mk(0,1,0,0,0,0, 32'h1008,0,0,0,                       1,0,32'h1008,32'h0,0,0,1,32'h77,32'hCAFE0002));
    tbl.push_back(mk(0,1,1,0,0,0, 32'h1008,0,0,0,                       1,0,32'h1008,32'h0,0,0,1,32'h77,32'hCAFE0002));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,32'h99,                         0,0,32'h1008,32'h0,0,0,1,32'h77,32'hCAFE0002));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,                              0,0,32'h1008,32'h0,0,0,0,32'h77,32'hCAFE0002));
    // next fetch served normally
    tbl.push_back(mk(0,1,0,0,0,0, 32'h100C,0,0,0,                       1,0,32'h100C,32'h0,0,0,1,32'h77,32'hCAFE0002));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,32'hAA,                         0,0,32'h100C,32'h0,1,0,1,32'hAA,32'hCAFE0002));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,                              0,0,32'h100C,32'h0,0,0,0,32'hAA,32'hCAFE0002));
    // abort in IDLE has no effect on the following fetch
    tbl.push_back(mk(0,0,1,0,0,0, 0,0,0,0,                              0,0,32'h100C,32'h0,0,0,0,32'hAA,32'hCAFE0002));
    tbl.push_back(mk(0,1,0,0,0,0, 32'h1010,0,0,0,                       1,0,32'h1010,32'h0,0,0,1,32'hAA,32'hCAFE0002));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,32'hBB,                         0,0,32'h1010,32'h0,1,0,1,32'hBB,32'hCAFE0002));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,                              0,0,32'h1010,32'h0,0,0,0,32'hBB,32'hCAFE0002));
    // stray mem_ack in IDLE ignored
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,32'hEE,                         0,0,32'h1010,32'h0,0,0,0,32'hBB,32'hCAFE0002));
    // reset mid-transaction, then stray ack
    tbl.push_back(mk(0,0,0,0,1,0, 0,32'h4000,32'h12345678,0,            1,1,32'h4000,32'h12345678,0,0,1,32'hBB,32'hCAFE0002));
    tbl.push_back(mk(1,0,0,0,1,0, 0,32'h4000,32'h12345678,0,            0,0,32'h0,32'h0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,32'h5A5A5A5A,                   0,0,32'h0,32'h0,0,0,0,32'h0,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,                              0,0,32'h0,32'h0,0,0,0,32'h0,32'h0));

    rst = 1'b1; if_re = 0; if_abort = 0; ds_re = 0; ds_we = 0; mem_ack = 0;
    if_addr = 0; ds_addr = 0; ds_wdata = 0; mem_rdata = 0;
    if_len = 2'd1; ds_len = 2'd2;

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      check_vec(i, tbl[i]);
    end

    // Burst limit: fetch and data read both held; expect 4 data grants then 1 fetch, repeated.
    begin
      logic exp_fetch;
      int   k;
      if_re = 1'b1; ds_re = 1'b1; if_addr = 32'hA000; ds_addr = 32'hB000;
      for (int t = 0; t < 10; t++) begin
        exp_fetch = ((t % 5) == 4);
        k = 0;
        while (!mem_req && k < 20) begin
          @(negedge clk);
          k++;
        end
        n_checks++;
        if (!mem_req) begin
          n_fail++;
          $display("FAIL burst_grant_timeout txn %0d: mem_req=0 expected 1 within 20 cycles", t);
          break;
        end
        chk("burst_addr", t, mem_addr, exp_fetch ? 32'hA000 : 32'hB000);
        chk("burst_len",  t, {30'd0, mem_len}, exp_fetch ? 32'd1 : 32'd2);
        mem_ack = 1'b1; mem_rdata = 32'h100 + t;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("burst_rack",  t, {31'd0, if_rack}, {31'd0, exp_fetch});
        chk("burst_dsack", t, {31'd0, ds_ack},  {31'd0, !exp_fetch});
        $display("burst txn %0d: addr=%08h rack=%0b dsack=%0b", t, mem_addr, if_rack, ds_ack);
      end
      if_re = 1'b0; ds_re = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("burst_idle", 0, {31'd0, busy}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_L, default 32, address width.
REQ-002 SHALL have parameter DATA_L, default 32, data width.
REQ-003 SHALL have parameter DS_BURST, default 4, maximum consecutive data-side grants while fetch waits (range 1-15).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have fetch ports if_re (in, 1, read request, level), if_addr (in, ADDR_L), if_len (in, 2), if_abort (in, 1, discard in-flight fetch), if_rack (out, 1, one-cycle done pulse), if_rdata (out, DATA_L).
REQ-007 SHALL have data-stage ports ds_re (in, 1), ds_we (in, 1), ds_addr (in, ADDR_L), ds_wdata (in, DATA_L), ds_len (in, 2), ds_ack (out, 1, one-cycle done pulse), ds_rdata (out, DATA_L).
REQ-008 SHALL have memory ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, ADDR_L), mem_wdata (out, DATA_L), mem_len (out, 2), mem_ack (in, 1, one-cycle pulse), mem_rdata (in, DATA_L).
REQ-009 SHALL have port busy (out, 1), high in any state other than IDLE.

Function
REQ-010 SHALL implement states IDLE, GNT_IF, GNT_DS, DONE.
REQ-011 IDLE: ds request (ds_re|ds_we) wins unless ds_cnt==DS_BURST and if_re high, in which case fetch wins; otherwise if_re alone -> GNT_IF.
REQ-012 On grant edge SHALL latch the winner's addr/len/we/wdata into mem_* registers and assert mem_req; mem_req high first cycle after request sampled (1-cycle issue latency).
REQ-013 mem_* outputs SHALL hold stable from grant until mem_ack sampled high; requester inputs changing mid-transaction are ignored.
REQ-014 On mem_ack in GNT_x: mem_req, mem_we drop next edge; mem_rdata registered into the winner's rdata; winner's ack pulses high for exactly that next cycle; state -> DONE.
REQ-015 ds_we transactions SHALL leave ds_rdata unchanged; ds_re and ds_we both high is treated as write.
REQ-016 DONE lasts exactly one cycle, ignores all requests (prevents re-issue of a still-high request), then -> IDLE.
REQ-017 Request-to-ack latency minimum 3 cycles with mem_ack on first mem_req cycle.
REQ-018 ds_cnt (4-bit): increments on each ds grant while if_re high, saturating at DS_BURST; clears on each fetch grant and whenever if_re low in IDLE.
REQ-019 if_abort high in any cycle of GNT_IF SHALL set an abort flag; on completion if_rack stays low and if_rdata unchanged; memory transaction still completes.
REQ-020 if_abort in IDLE/DONE/GNT_DS SHALL have no effect; abort flag clears on entering DONE.
REQ-021 mem_ack outside GNT_IF/GNT_DS SHALL be ignored.
REQ-022 if_rack and ds_ack SHALL never be high in the same cycle; at most one memory transaction outstanding.

Reset
REQ-023 rst high at clock edge -> state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_len=0, if_rack=0, ds_ack=0, if_rdata=0, ds_rdata=0, ds_cnt=0, abort flag=0, busy=0.
REQ-024 rst mid-transaction SHALL abandon it without ack; a later stray mem_ack SHALL be ignored per REQ-021.

Verification
REQ-025 if_re=1, if_addr=0x1000, mem_ack one cycle after mem_req with mem_rdata=0x00000013 -> mem_addr=0x1000, mem_we=0, if_rack single pulse, if_rdata=0x00000013, ds_ack=0.
REQ-026 if_re and ds_we same cycle, ds_addr=0x2000, ds_wdata=0xDEADBEEF -> data served first (mem_we=1, mem_addr=0x2000), ds_ack pulse, then fetch granted after DONE.
REQ-027 if_re held, ds_re continuously requested, DS_BURST=4 -> exactly 4 ds grants, then 1 fetch grant, pattern repeats.
REQ-028 fetch in GNT_IF, if_abort pulsed 1 cycle before mem_ack -> mem transaction completes, if_rack never asserts, if_rdata unchanged; next if_re served normally.
REQ-029 rst asserted while mem_req=1, then stray mem_ack -> all outputs at reset values, no ack pulse, state IDLE.
REQ-030 requester holds request one cycle after its ack -> no second mem_req issued from DONE; re-issued only if still high in IDLE.
